mac_window_accumulator: RTL and testbench

// - Sits directly downstream of the 8x8 signed multiplier stage.
// - Consumes its sign-extended 20-bit product stream and sums acc_len consecutive valid products
//   (one kernel window / channel group) into a wide signed accumulator.
// - Emits one registered partial sum per window to the bias/requant stage.
// - Back-to-back windows are accepted with no bubble cycle.

---
 rtl/mac_window_accumulator_pkg.sv | 16 +
 rtl/mac_window_accumulator_if.sv | 31 +++
 rtl/mac_sat_clip.sv | 42 ++++
 rtl/mac_window_accumulator.sv | 116 +++++++++++
 tb/tb_mac_window_accumulator.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mac_window_accumulator_pkg.sv
// Shared widths and state encoding for the MAC window accumulator slice.
// PROD_W is derived from the multiplier's output data width.
package mac_window_accumulator_pkg;

  localparam int unsigned WIDTH_DATA_OUT = 10;
  localparam int unsigned PROD_W_DEF     = 2 * WIDTH_DATA_OUT;
  localparam int unsigned ACC_W_DEF      = 32;
  localparam int unsigned OUT_W_DEF      = 32;
  localparam int unsigned LEN_W_DEF      = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

endpackage

// File: rtl/mac_window_accumulator_if.sv
// Product-stream in / window-sum out bundle between the multiplier, the accumulator and requant.
// The master drives products, the slave (accumulator) drives sums and status.
interface mac_window_accumulator_if
  import mac_window_accumulator_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
);

  logic        [LEN_W-1:0]  acc_len;
  logic signed [PROD_W-1:0] prod_in;
  logic                     prod_valid;
  logic                     flush;
  logic signed [OUT_W-1:0]  sum_out;
  logic                     sum_valid;
  logic                     sat_flag;
  logic                     busy;
  logic        [LEN_W-1:0]  win_cnt;

  modport master (
    output acc_len, prod_in, prod_valid, flush,
    input  sum_out, sum_valid, sat_flag, busy, win_cnt
  );

  modport slave (
    input  acc_len, prod_in, prod_valid, flush,
    output sum_out, sum_valid, sat_flag, busy, win_cnt
  );

endinterface

// File: rtl/mac_sat_clip.sv
// Combinational ACC_W -> OUT_W narrowing of the final window sum.
// ACC_SAT_EN selects clamp-to-range with a saturation flag; otherwise plain truncation.
module mac_sat_clip
  import mac_window_accumulator_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] sum_o,
  output logic                    sat_o
);

  if (OUT_W < ACC_W) begin : g_narrow
`ifdef ACC_SAT_EN
    logic in_range;

    // In range iff every bit above the output sign bit copies it.
    always_comb begin
      in_range = (acc_i[ACC_W-1:OUT_W-1] == '0) || (acc_i[ACC_W-1:OUT_W-1] == '1);
      sat_o    = ~in_range;
      if (in_range) begin
        sum_o = acc_i[OUT_W-1:0];
      end else if (acc_i[ACC_W-1]) begin
        sum_o = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        sum_o = {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
`else
    logic unused_hi;

    assign unused_hi = ^acc_i[ACC_W-1:OUT_W];
    assign sum_o     = acc_i[OUT_W-1:0];
    assign sat_o     = 1'b0;
`endif
  end else begin : g_full
    assign sum_o = acc_i;
    assign sat_o = 1'b0;
  end

endmodule

// File: rtl/mac_window_accumulator.sv
// Sums acc_len consecutive signed products into one registered partial sum per window.
// Build option ACC_SAT_EN clamps the emitted sum to OUT_W instead of truncating it.
module mac_window_accumulator
  import mac_window_accumulator_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input logic                    clk,
  input logic                    rst_n,
  mac_window_accumulator_if.slave bus
);

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic        [LEN_W-1:0]   cnt_q, cnt_d;
  logic        [LEN_W-1:0]   len_q, len_d;
  logic signed [OUT_W-1:0]   sum_q, sum_d;
  logic                      sum_valid_q, sum_valid_d;
  logic                      sat_q, sat_d;

  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_sum;
  logic        [LEN_W-1:0]   len_in;
  logic        [LEN_W-1:0]   len_eff;
  logic        [LEN_W-1:0]   cnt_inc;
  logic signed [OUT_W-1:0]   clip_sum;
  logic                      clip_sat;

  assign prod_ext = {{(ACC_W-PROD_W){bus.prod_in[PROD_W-1]}}, bus.prod_in};
  assign len_in   = (bus.acc_len == '0) ? LEN_W'(1) : bus.acc_len;

  // The first product of a window starts from zero and uses the live acc_len.
  always_comb begin
    if (state_q == ST_ACC) begin
      acc_sum = acc_q + prod_ext;
      cnt_inc = cnt_q + LEN_W'(1);
      len_eff = len_q;
    end else begin
      acc_sum = prod_ext;
      cnt_inc = LEN_W'(1);
      len_eff = len_in;
    end
  end

  mac_sat_clip #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_sat_clip (
    .acc_i (acc_sum),
    .sum_o (clip_sum),
    .sat_o (clip_sat)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    sum_d       = sum_q;
    sat_d       = sat_q;
    sum_valid_d = 1'b0;

    if (bus.flush) begin
      // Flush wins over a coincident product; that product is dropped.
      if (state_q == ST_ACC) begin
        state_d = ST_IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    end else if (bus.prod_valid) begin
      len_d = len_eff;
      if (cnt_inc == len_eff) begin
        state_d     = ST_IDLE;
        acc_d       = '0;
        cnt_d       = '0;
        sum_d       = clip_sum;
        sat_d       = clip_sat;
        sum_valid_d = 1'b1;
      end else begin
        state_d = ST_ACC;
        acc_d   = acc_sum;
        cnt_d   = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      sum_q       <= '0;
      sat_q       <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      sat_q       <= sat_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign bus.sum_out   = sum_q;
  assign bus.sum_valid = sum_valid_q;
  assign bus.sat_flag  = sat_q;
  assign bus.busy      = (state_q == ST_ACC);
  assign bus.win_cnt   = cnt_q;

endmodule

// File: tb/tb_mac_window_accumulator.sv
// Directed bench: two accumulators (OUT_W=32 and OUT_W=16) share one product stream;
// a window model pushes expected sums and strobe cycles, a negedge monitor pops and compares.
module tb_mac_window_accumulator;
  import mac_window_accumulator_pkg::*;

  localparam int unsigned PW = PROD_W_DEF;
  localparam int unsigned LW = LEN_W_DEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mac_window_accumulator_if #(.OUT_W(32)) if_a ();
  mac_window_accumulator_if #(.OUT_W(16)) if_b ();

  mac_window_accumulator #(.OUT_W(32)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  mac_window_accumulator #(.OUT_W(16)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  typedef struct {
    longint sum;
    int     cyc;
  } exp_t;

  exp_t   sb[$];
  int     vectors = 0;
  int     miscompares = 0;
  int     len_cur = 0;
  bit     m_open = 0;
  int     m_len = 0;
  int     m_cnt = 0;
  longint m_sum = 0;

  task automatic check(input string tag, input longint obs, input longint expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint exp16(input longint s);
`ifdef ACC_SAT_EN
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
`else
    logic signed [15:0] t;
    t = s[15:0];
    return longint'(t);
`endif
  endfunction

  function automatic longint sat16(input longint s);
`ifdef ACC_SAT_EN
    return (s > 32767 || s < -32768) ? 1 : 0;
`else
    return (s != s) ? 1 : 0;
`endif
  endfunction

  task automatic drive(input bit v, input int p, input bit f);
    logic [PW-1:0] pv;
    logic [LW-1:0] lv;
    pv = p[PW-1:0];
    lv = len_cur[LW-1:0];
    if_a.prod_valid = v; if_a.prod_in = pv; if_a.acc_len = lv; if_a.flush = f;
    if_b.prod_valid = v; if_b.prod_in = pv; if_b.acc_len = lv; if_b.flush = f;
  endtask

  task automatic send(input int p);
    drive(1'b1, p, 1'b0);
    if (!m_open) begin
      m_len  = (len_cur == 0) ? 1 : len_cur;
      m_cnt  = 1;
      m_sum  = p;
      m_open = 1;
    end else begin
      m_cnt++;
      m_sum += p;
    end
    if (m_cnt == m_len) begin
      sb.push_back('{m_sum, cyc + 1});
      m_open = 0;
    end
    @(posedge clk);
    #1;
    drive(1'b0, 0, 1'b0);
  endtask

  task automatic flush_with(input int p);
    drive(1'b1, p, 1'b1);
    m_open = 0;
    @(posedge clk);
    #1;
    drive(1'b0, 0, 1'b0);
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_sum_a"}, if_a.sum_out, 0);
    check({tag, "_valid_a"}, if_a.sum_valid, 0);
    check({tag, "_sat_a"}, if_a.sat_flag, 0);
    check({tag, "_busy_a"}, if_a.busy, 0);
    check({tag, "_win_a"}, if_a.win_cnt, 0);
    check({tag, "_sum_b"}, if_b.sum_out, 0);
    check({tag, "_sat_b"}, if_b.sat_flag, 0);
  endtask

  initial begin
    drive(1'b0, 0, 1'b0);
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (if_a.sum_valid || if_b.sum_valid) begin
          check("strobe_pair", {if_a.sum_valid, if_b.sum_valid}, 3);
          check("strobe_expected", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("strobe_cycle", cyc, e.cyc);
            check("sum_a", if_a.sum_out, longint'(int'(e.sum)));
            check("sat_a", if_a.sat_flag, 0);
            check("sum_b", if_b.sum_out, exp16(e.sum));
            check("sat_b", if_b.sat_flag, sat16(e.sum));
          end
        end
      end
    join_none

    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    gap(1);

    // 1..9 in one window of nine
    len_cur = 9;
    for (int i = 1; i <= 9; i++) begin
      send(i);
      if (i == 3) begin
        check("win_cnt_mid", if_a.win_cnt, 3);
        check("busy_mid", if_a.busy, 1);
      end
    end
    check("win_cnt_after", if_a.win_cnt, 0);
    check("busy_after", if_a.busy, 0);
    gap(2);

    // Most negative product exercises sign extension
    len_cur = 3;
    send(-524288); send(5); send(-1);
    gap(2);

    // Back-to-back windows, no bubble
    len_cur = 4;
    for (int i = 0; i < 4; i++) send(2);
    for (int i = 0; i < 4; i++) send(-3);
    gap(2);

    // Flush with a coincident product drops the window
    send(5); send(6);
    flush_with(9);
    check("busy_flush", if_a.busy, 0);
    check("win_cnt_flush", if_a.win_cnt, 0);
    for (int i = 0; i < 4; i++) send(7);
    gap(2);

    // acc_len=0 behaves as 1
    len_cur = 0;
    send(3); send(-4); send(10);
    gap(2);

    // Length latched at window open
    len_cur = 5;
    send(1);
    len_cur = 2;
    for (int i = 2; i <= 5; i++) begin
      send(i);
      if (i == 4) check("win_cnt_len_latch", if_a.win_cnt, 4);
    end
    gap(2);

    // Output-width overflow on the narrow instance
    len_cur = 2;
    send(400000); send(400000);
    gap(2);

    // Asynchronous reset mid-window
    len_cur = 9;
    send(10); send(20); send(30);
    check("busy_pre_reset", if_a.busy, 1);
    rst_n = 1'b0;
    m_open = 0;
    #1;
    check_idle_outputs("async_reset");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 11; i <= 19; i++) send(i);
    gap(3);

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
